// File: rtl/crypto_input_arbiter.sv
// Packet-granularity round-robin arbiter feeding two AXI4-Stream requesters into one crypto stream.
// Optional per-requester packet counters are enabled by defining CRYPTO_ARB_STATS_EN.
module crypto_input_arbiter #(
   parameter int C_AXIS_DATA_WIDTH  = 256,
   parameter int C_AXIS_TUSER_WIDTH = 128
) (
   input  logic                             axis_aclk,
   input  logic                             axis_reset,

   input  logic [C_AXIS_DATA_WIDTH-1:0]     s0_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]   s0_axis_tkeep,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]    s0_axis_tuser,
   input  logic                             s0_axis_tvalid,
   output logic                             s0_axis_tready,
   input  logic                             s0_axis_tlast,

   input  logic [C_AXIS_DATA_WIDTH-1:0]     s1_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]   s1_axis_tkeep,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]    s1_axis_tuser,
   input  logic                             s1_axis_tvalid,
   output logic                             s1_axis_tready,
   input  logic                             s1_axis_tlast,

   output logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             m_axis_tlast,

   input  logic                             stats_clear,
   output logic [31:0]                      pkt_cnt0,
   output logic [31:0]                      pkt_cnt1
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t state_q;
   logic   sel_q;
   logic   last_served_q;

   logic   granted;
   logic   beat_accept;
   logic   tlast_accept;

   // Outputs are forced quiet while reset is held, even if the old grant is still registered.
   assign granted = (state_q == GRANT) && !axis_reset;

   assign m_axis_tdata  = sel_q ? s1_axis_tdata  : s0_axis_tdata;
   assign m_axis_tkeep  = sel_q ? s1_axis_tkeep  : s0_axis_tkeep;
   assign m_axis_tuser  = sel_q ? s1_axis_tuser  : s0_axis_tuser;
   assign m_axis_tlast  = sel_q ? s1_axis_tlast  : s0_axis_tlast;
   assign m_axis_tvalid = granted && (sel_q ? s1_axis_tvalid : s0_axis_tvalid);

   assign s0_axis_tready = granted && !sel_q && m_axis_tready;
   assign s1_axis_tready = granted &&  sel_q && m_axis_tready;

   assign beat_accept  = m_axis_tvalid && m_axis_tready;
   assign tlast_accept = beat_accept && m_axis_tlast;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge axis_aclk) begin
      if (axis_reset) begin
         state_q       <= IDLE;
         sel_q         <= 1'b0;
         last_served_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (s0_axis_tvalid || s1_axis_tvalid) begin
                  state_q <= GRANT;
                  sel_q   <= (s0_axis_tvalid && s1_axis_tvalid) ? !last_served_q : s1_axis_tvalid;
               end
            end
            GRANT: begin
               if (tlast_accept) begin
                  last_served_q <= sel_q;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef CRYPTO_ARB_STATS_EN
   logic [31:0] pkt_cnt0_q;
   logic [31:0] pkt_cnt1_q;

   // Clear takes priority over a coincident end-of-packet increment.
   always_ff @(posedge axis_aclk) begin
      if (axis_reset || stats_clear) begin
         pkt_cnt0_q <= 32'd0;
         pkt_cnt1_q <= 32'd0;
      end else if (tlast_accept) begin
         if (sel_q) pkt_cnt1_q <= pkt_cnt1_q + 32'd1;
         else       pkt_cnt0_q <= pkt_cnt0_q + 32'd1;
      end
   end

   assign pkt_cnt0 = pkt_cnt0_q;
   assign pkt_cnt1 = pkt_cnt1_q;
`else
   logic stats_unused;
   assign stats_unused = stats_clear;
   assign pkt_cnt0     = 32'd0;
   assign pkt_cnt1     = 32'd0;
`endif

   a_single_ready: assert property (@(posedge axis_aclk) !(s0_axis_tready && s1_axis_tready));

   a_grant_held: assert property (@(posedge axis_aclk) disable iff (axis_reset)
      (state_q == GRANT && !tlast_accept) |=> (state_q == GRANT && $stable(sel_q)));

endmodule

// File: tb/tb_crypto_input_arbiter.sv
// Directed bench for crypto_input_arbiter: a packet-level model checks every cycle,
// and literal beat timelines pin the model for each scenario.
module tb_crypto_input_arbiter;
   localparam int DW = 256;
   localparam int UW = 128;
   localparam int KW = DW / 8;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   typedef struct packed {
      int   t;
      int   tag;
      logic last;
   } obs_t;

   logic          clk = 1'b0;
   logic          axis_reset;
   logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
   logic [KW-1:0] s0_tkeep, s1_tkeep, m_tkeep;
   logic [UW-1:0] s0_tuser, s1_tuser, m_tuser;
   logic          s0_tvalid, s1_tvalid, m_tvalid;
   logic          s0_tready, s1_tready, m_tready;
   logic          s0_tlast, s1_tlast, m_tlast;
   logic          stats_clear;
   logic [31:0]   pkt_cnt0, pkt_cnt1;

   always #5 clk = ~clk;

   crypto_input_arbiter #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)) dut (
      .axis_aclk      (clk),
      .axis_reset     (axis_reset),
      .s0_axis_tdata  (s0_tdata),
      .s0_axis_tkeep  (s0_tkeep),
      .s0_axis_tuser  (s0_tuser),
      .s0_axis_tvalid (s0_tvalid),
      .s0_axis_tready (s0_tready),
      .s0_axis_tlast  (s0_tlast),
      .s1_axis_tdata  (s1_tdata),
      .s1_axis_tkeep  (s1_tkeep),
      .s1_axis_tuser  (s1_tuser),
      .s1_axis_tvalid (s1_tvalid),
      .s1_axis_tready (s1_tready),
      .s1_axis_tlast  (s1_tlast),
      .m_axis_tdata   (m_tdata),
      .m_axis_tkeep   (m_tkeep),
      .m_axis_tuser   (m_tuser),
      .m_axis_tvalid  (m_tvalid),
      .m_axis_tready  (m_tready),
      .m_axis_tlast   (m_tlast),
      .stats_clear    (stats_clear),
      .pkt_cnt0       (pkt_cnt0),
      .pkt_cnt1       (pkt_cnt1)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int base     = 0;

   beat_t q0[$];
   beat_t q1[$];
   obs_t  log_q[$];

   // Stimulus controls, changed between cycles by the test sequence.
   logic rst  = 1'b1;
   logic en0  = 1'b1;
   logic en1  = 1'b1;
   logic mrdy = 1'b1;
   logic clr  = 1'b0;

   // Packet-level model: which requester owns the stream (-1 = none) and who was served last.
   int          owner    = -1;
   int          last_srv = 1;
   logic [31:0] mc0      = '0;
   logic [31:0] mc1      = '0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [7:0] tag);
      return {8'hC0, ~tag, 8'h5A, tag};
   endfunction

   function automatic logic [UW-1:0] user_of(input logic [DW-1:0] d);
      return {d[31:0], ~d[31:0], d[31:0], ~d[31:0]};
   endfunction

   task automatic add_pkt(input int src, input int first_seq, input int n);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.data = {8{word_of(8'(src * 16 + first_seq + i))}};
         b.last = (i == n - 1);
         if (src == 0) q0.push_back(b);
         else          q1.push_back(b);
      end
   endtask

   task automatic step();
      beat_t h0, h1, hs;
      logic  v0, v1, sv, e_v, e_r0, e_r1, pop0, pop1;
      obs_t  o;
      string pfx;

      @(negedge clk);
      v0 = en0 && (q0.size() > 0);
      v1 = en1 && (q1.size() > 0);
      h0 = (q0.size() > 0) ? q0[0] : '0;
      h1 = (q1.size() > 0) ? q1[0] : '0;
      s0_tdata = h0.data; s0_tkeep = h0.data[KW-1:0]; s0_tuser = user_of(h0.data);
      s0_tlast = h0.last; s0_tvalid = v0;
      s1_tdata = h1.data; s1_tkeep = h1.data[KW-1:0]; s1_tuser = user_of(h1.data);
      s1_tlast = h1.last; s1_tvalid = v1;
      axis_reset  = rst;
      m_tready    = mrdy;
      stats_clear = clr;
      #1;

      e_v = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0;
      hs  = (owner == 1) ? h1 : h0;
      sv  = (owner == 1) ? v1 : v0;
      if (!rst && owner >= 0) begin
         e_v  = sv;
         e_r0 = (owner == 0) && mrdy;
         e_r1 = (owner == 1) && mrdy;
      end

      pfx = $sformatf("c%0d", cyc - base);
      check({pfx, " m_tvalid"}, m_tvalid, e_v);
      check({pfx, " s0_tready"}, s0_tready, e_r0);
      check({pfx, " s1_tready"}, s1_tready, e_r1);
      if (e_v) begin
         check({pfx, " m_tdata"}, m_tdata, hs.data);
         check({pfx, " m_tkeep"}, m_tkeep, hs.data[KW-1:0]);
         check({pfx, " m_tuser"}, m_tuser, user_of(hs.data));
         check({pfx, " m_tlast"}, m_tlast, hs.last);
      end
      if (!rst) begin
         check({pfx, " pkt_cnt0"}, pkt_cnt0, mc0);
         check({pfx, " pkt_cnt1"}, pkt_cnt1, mc1);
      end

      if (m_tvalid && m_tready) begin
         o.t = cyc - base; o.tag = int'(m_tdata[7:0]); o.last = m_tlast;
         log_q.push_back(o);
      end
      pop0 = s0_tvalid && s0_tready;
      pop1 = s1_tvalid && s1_tready;

      @(posedge clk);
      #1;
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());

      if (rst) begin
         owner = -1; last_srv = 1; mc0 = '0; mc1 = '0;
      end else if (owner < 0) begin
         if (v0 && v1) owner = 1 - last_srv;
         else if (v0)  owner = 0;
         else if (v1)  owner = 1;
      end else if (sv && mrdy && hs.last) begin
`ifdef CRYPTO_ARB_STATS_EN
         if (owner == 0) mc0 = mc0 + 32'd1;
         else            mc1 = mc1 + 32'd1;
`endif
         last_srv = owner;
         owner    = -1;
      end
`ifdef CRYPTO_ARB_STATS_EN
      if (clr && !rst) begin mc0 = '0; mc1 = '0; end
`endif
      cyc++;
   endtask

   task automatic do_reset();
      q0.delete(); q1.delete();
      en0 = 1'b1; en1 = 1'b1; mrdy = 1'b1; clr = 1'b0;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      log_q.delete();
      base = cyc;
   endtask

   task automatic check_beat(input string name, input int idx, input int tag, input int t,
                             input logic last);
      if (log_q.size() > idx) begin
         check($sformatf("%s beat%0d tag", name, idx), log_q[idx].tag, tag);
         check($sformatf("%s beat%0d cycle", name, idx), log_q[idx].t, t);
         check($sformatf("%s beat%0d tlast", name, idx), log_q[idx].last, last);
      end else begin
         check($sformatf("%s beat%0d present", name, idx), log_q.size(), idx + 1);
      end
   endtask

   initial begin
      logic [31:0] exp0, exp1;

      // Single 3-beat packet from s0: bubble on cycle 0, beats on cycles 1..3.
      do_reset();
      add_pkt(0, 1, 3);
      repeat (6) step();
      check("t1 beats", log_q.size(), 3);
      check_beat("t1", 0, 'h01, 1, 1'b0);
      check_beat("t1", 1, 'h02, 2, 1'b0);
      check_beat("t1", 2, 'h03, 3, 1'b1);

      // Both requesters contending with 2-beat packets: strict alternation s0,s1,s0,s1.
      do_reset();
      add_pkt(0, 1, 2); add_pkt(0, 3, 2);
      add_pkt(1, 1, 2); add_pkt(1, 3, 2);
      repeat (14) step();
      check("t2 beats", log_q.size(), 8);
      check_beat("t2", 0, 'h01, 1, 1'b0);
      check_beat("t2", 1, 'h02, 2, 1'b1);
      check_beat("t2", 2, 'h11, 4, 1'b0);
      check_beat("t2", 3, 'h12, 5, 1'b1);
      check_beat("t2", 4, 'h03, 7, 1'b0);
      check_beat("t2", 5, 'h04, 8, 1'b1);
      check_beat("t2", 6, 'h13, 10, 1'b0);
      check_beat("t2", 7, 'h14, 11, 1'b1);

      // s0 raises valid mid s1 packet: s1 completes uninterrupted, s0 follows after one bubble.
      do_reset();
      add_pkt(1, 1, 4); add_pkt(0, 1, 1);
      en0 = 1'b0;
      step(); step();
      en0 = 1'b1;
      repeat (6) step();
      check("t3 beats", log_q.size(), 5);
      check_beat("t3", 0, 'h11, 1, 1'b0);
      check_beat("t3", 3, 'h14, 4, 1'b1);
      check_beat("t3", 4, 'h01, 6, 1'b1);

      // Backpressure toggling and a 2-cycle valid drop inside an s0 packet, s1 waiting.
      do_reset();
      add_pkt(0, 1, 4); add_pkt(1, 1, 1);
      step(); step();
      mrdy = 1'b0; step();
      mrdy = 1'b1; step();
      mrdy = 1'b0; step();
      mrdy = 1'b1; en0 = 1'b0; step(); step();
      en0 = 1'b1;
      repeat (6) step();
      check("t4 beats", log_q.size(), 5);
      check_beat("t4", 0, 'h01, 1, 1'b0);
      check_beat("t4", 1, 'h02, 3, 1'b0);
      check_beat("t4", 2, 'h03, 7, 1'b0);
      check_beat("t4", 3, 'h04, 8, 1'b1);
      check_beat("t4", 4, 'h11, 10, 1'b1);

      // Reset on beat 2 of a 5-beat s1 packet: beat withheld, s0 served first afterwards.
      do_reset();
      add_pkt(1, 1, 5); add_pkt(0, 1, 1);
      en0 = 1'b0;
      step(); step();
      en0 = 1'b1; rst = 1'b1; step();
      rst = 1'b0;
      repeat (7) step();
      check("t5 beats", log_q.size(), 6);
      check_beat("t5", 0, 'h11, 1, 1'b0);
      check_beat("t5", 1, 'h01, 4, 1'b1);
      check_beat("t5", 2, 'h12, 6, 1'b0);
      check_beat("t5", 5, 'h15, 9, 1'b1);

      // Packet counters: 5 s0 and 3 s1 single-beat packets, then a clear coincident with tlast.
      do_reset();
      for (int i = 0; i < 5; i++) add_pkt(0, i, 1);
      for (int i = 0; i < 3; i++) add_pkt(1, i, 1);
      repeat (20) step();
      check("t6 beats", log_q.size(), 8);
`ifdef CRYPTO_ARB_STATS_EN
      exp0 = 32'd5; exp1 = 32'd3;
`else
      exp0 = 32'd0; exp1 = 32'd0;
`endif
      check("t6 pkt_cnt0", pkt_cnt0, exp0);
      check("t6 pkt_cnt1", pkt_cnt1, exp1);
      add_pkt(0, 9, 1);
      step();
      clr = 1'b1; step();
      clr = 1'b0; step();
      check("t6 beats after clear", log_q.size(), 9);
      check("t6 pkt_cnt0 cleared", pkt_cnt0, 32'd0);
      check("t6 pkt_cnt1 cleared", pkt_cnt1, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
